ann_bank_sequencer: RTL and testbench

Parametrised load/handshake sequencer between the Avalon verification bus and the ANN core.
- On start, fetches the image and NUM_BANKS coefficient banks one at a time over the bus request/busy handshake.
- Registers each returned frame and hands each bank to the core with a one-cycle pulse.
- Collects the classified digit and drives the seven-segment display with done/error status.
- Replaces the single-bank, free-running loaded-edge glue. Adds bank sequencing, timeout, an error state and a registered result.

---
 rtl/ann_pkg.sv | 38 +++
 rtl/ann_seg_decoder.sv | 11 +
 rtl/ann_bank_sequencer.sv | 147 ++++++++++++++
 tb/tb_ann_bank_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ann_pkg.sv
// Shared types and constants for the ANN bank sequencer: FSM states,
// seven-segment codes and the digit-to-segment lookup.
package ann_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_HI,
        WAIT_LO,
        HANDOFF,
        WAIT_RESULT,
        DONE,
        ERROR
    } state_t;

    localparam logic [7:0] SEG_DASH = 8'h40;
    localparam logic [7:0] SEG_E    = 8'h79;

    // Segment bits are {dp,g,f,e,d,c,b,a}, active-high; anything above 9 shows a dash.
    function automatic logic [7:0] seg_decode(input logic [3:0] digit);
        logic [7:0] seg;
        case (digit)
            4'd0:    seg = 8'h3F;
            4'd1:    seg = 8'h06;
            4'd2:    seg = 8'h5B;
            4'd3:    seg = 8'h4F;
            4'd4:    seg = 8'h66;
            4'd5:    seg = 8'h6D;
            4'd6:    seg = 8'h7D;
            4'd7:    seg = 8'h07;
            4'd8:    seg = 8'h7F;
            4'd9:    seg = 8'h6F;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ann_seg_decoder.sv
// Combinational classified-digit to seven-segment decode.
module ann_seg_decoder
    import ann_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] seg
);

    assign seg = seg_decode(digit);

endmodule

// File: rtl/ann_bank_sequencer.sv
// Fetches the image and NUM_BANKS coefficient banks over the bus, hands each
// bank to the ANN core, and shows the classified digit or an error code.
module ann_bank_sequencer
    import ann_pkg::*;
#(
    parameter int IMAGE_SIZE    = 64,
    parameter int LAYER_NEURONS = 16,
    parameter int DATA_W        = 16,
    parameter int NUM_BANKS     = 4,
    parameter int SEL_W         = 2,
    parameter int ADDR_W        = 10,
    parameter int TIMEOUT       = 1024
) (
    input  logic                                     clk,
    input  logic                                     n_reset,
    input  logic                                     start_detecting,
    input  logic [ADDR_W-1:0]                        image_address,
    output logic                                     bus_get_data,
    output logic [SEL_W-1:0]                         bus_which_data,
    output logic [ADDR_W-1:0]                        bus_image_addr,
    input  logic                                     bus_busy,
    input  logic [IMAGE_SIZE*DATA_W-1:0]             bus_image_data,
    input  logic [LAYER_NEURONS*IMAGE_SIZE*DATA_W-1:0] bus_coeff_data,
    output logic [IMAGE_SIZE*DATA_W-1:0]             core_image,
    output logic [LAYER_NEURONS*IMAGE_SIZE*DATA_W-1:0] core_weights,
    output logic [SEL_W-1:0]                         core_bank,
    output logic                                     core_loaded,
    input  logic                                     core_bank_ack,
    input  logic                                     core_done,
    input  logic [3:0]                               core_digit,
    output logic [7:0]                               seven_seg,
    output logic                                     done_processing,
    output logic                                     error
);

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [SEL_W-1:0] BANK_LAST = SEL_W'(NUM_BANKS - 1);

    state_t             state;
    logic               start_q;
    logic               busy_q;
    logic [SEL_W-1:0]   bank_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [7:0]         digit_seg;

    logic start;
    logic start_ok;
    logic bus_complete;

    assign start        = start_detecting & ~start_q;
    assign start_ok     = (state == IDLE) || (state == DONE) || (state == ERROR);
    assign bus_complete = busy_q & ~bus_busy;

    ann_seg_decoder u_seg_decoder (
        .digit (core_digit),
        .seg   (digit_seg)
    );

    // Handshakes: bus_get_data is a one-cycle request, the bus answers with a
    // busy high period whose falling edge marks data valid; core_loaded is a
    // one-cycle valid and core_bank_ack (same cycle or later) releases the bank.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state           <= IDLE;
            start_q         <= 1'b0;
            busy_q          <= 1'b0;
            bank_cnt        <= '0;
            tmo_cnt         <= '0;
            bus_get_data    <= 1'b0;
            bus_which_data  <= '0;
            bus_image_addr  <= '0;
            core_image      <= '0;
            core_weights    <= '0;
            core_bank       <= '0;
            core_loaded     <= 1'b0;
            seven_seg       <= SEG_DASH;
            done_processing <= 1'b0;
            error           <= 1'b0;
        end else begin
            start_q      <= start_detecting;
            busy_q       <= bus_busy;
            bus_get_data <= 1'b0;
            core_loaded  <= 1'b0;

            if (start_ok && start) begin
                bus_image_addr  <= image_address;
                done_processing <= 1'b0;
                error           <= 1'b0;
                seven_seg       <= SEG_DASH;
                bank_cnt        <= '0;
                bus_which_data  <= '0;
                bus_get_data    <= 1'b1;
                state           <= REQ;
            end else begin
                case (state)
                    REQ: begin
                        tmo_cnt <= '0;
                        state   <= WAIT_HI;
                    end
                    WAIT_HI, WAIT_LO: begin
                        if ((state == WAIT_LO) && bus_complete) begin
                            core_weights <= bus_coeff_data;
                            if (bank_cnt == '0) begin
                                core_image <= bus_image_data;
                            end
                            core_bank   <= bank_cnt;
                            core_loaded <= 1'b1;
                            state       <= HANDOFF;
                        end else if (tmo_cnt == TMO_LAST) begin
                            error     <= 1'b1;
                            seven_seg <= SEG_E;
                            state     <= ERROR;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                            if ((state == WAIT_HI) && bus_busy) begin
                                state <= WAIT_LO;
                            end
                        end
                    end
                    HANDOFF: begin
                        if (core_bank_ack) begin
                            if (bank_cnt == BANK_LAST) begin
                                state <= WAIT_RESULT;
                            end else begin
                                bank_cnt       <= bank_cnt + 1'b1;
                                bus_which_data <= bank_cnt + 1'b1;
                                bus_get_data   <= 1'b1;
                                state          <= REQ;
                            end
                        end
                    end
                    WAIT_RESULT: begin
                        if (core_done) begin
                            seven_seg       <= digit_seg;
                            done_processing <= 1'b1;
                            state           <= DONE;
                        end
                    end
                    IDLE, DONE, ERROR: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ann_bank_sequencer.sv
// Directed bench for ann_bank_sequencer: bus and core responders, a strobe
// scoreboard and hand-computed display/packing expectations.
module tb_ann_bank_sequencer;

    localparam int IMAGE_SIZE    = 64;
    localparam int LAYER_NEURONS = 16;
    localparam int DATA_W        = 16;
    localparam int NUM_BANKS     = 4;
    localparam int SEL_W         = 2;
    localparam int ADDR_W        = 10;
    localparam int TIMEOUT       = 1024;

    // clock / reset
    logic clk = 1'b0;
    logic n_reset = 1'b1;
    always #5 clk = ~clk;

    logic                                      start_detecting = 1'b0;
    logic [ADDR_W-1:0]                         image_address = '0;
    logic                                      bus_get_data;
    logic [SEL_W-1:0]                          bus_which_data;
    logic [ADDR_W-1:0]                         bus_image_addr;
    logic                                      bus_busy = 1'b0;
    logic [IMAGE_SIZE*DATA_W-1:0]              bus_image_data = '0;
    logic [LAYER_NEURONS*IMAGE_SIZE*DATA_W-1:0] bus_coeff_data = '0;
    logic [IMAGE_SIZE*DATA_W-1:0]              core_image;
    logic [LAYER_NEURONS*IMAGE_SIZE*DATA_W-1:0] core_weights;
    logic [SEL_W-1:0]                          core_bank;
    logic                                      core_loaded;
    logic                                      core_bank_ack = 1'b0;
    logic                                      core_done = 1'b0;
    logic [3:0]                                core_digit = '0;
    logic [7:0]                                seven_seg;
    logic                                      done_processing;
    logic                                      error;

    ann_bank_sequencer #(
        .IMAGE_SIZE(IMAGE_SIZE), .LAYER_NEURONS(LAYER_NEURONS), .DATA_W(DATA_W),
        .NUM_BANKS(NUM_BANKS), .SEL_W(SEL_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .n_reset(n_reset), .start_detecting(start_detecting),
        .image_address(image_address), .bus_get_data(bus_get_data),
        .bus_which_data(bus_which_data), .bus_image_addr(bus_image_addr),
        .bus_busy(bus_busy), .bus_image_data(bus_image_data),
        .bus_coeff_data(bus_coeff_data), .core_image(core_image),
        .core_weights(core_weights), .core_bank(core_bank),
        .core_loaded(core_loaded), .core_bank_ack(core_bank_ack),
        .core_done(core_done), .core_digit(core_digit), .seven_seg(seven_seg),
        .done_processing(done_processing), .error(error)
    );

    int total = 0;
    int bad = 0;

    logic [SEL_W-1:0]  exp_q[$];
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [15:0]       img_base = 16'hA000;
    int bus_mode = 0;       // 0: normal responder, 2: never answers
    int ack_delay = 3;
    int exp_bank = 0;
    int strobe_cnt = 0;
    int loaded_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] wword(input logic [LAYER_NEURONS*IMAGE_SIZE*DATA_W-1:0] w,
                                          input int j, input int i);
        return w[(j*IMAGE_SIZE+i)*DATA_W +: DATA_W];
    endfunction

    // scoreboard: every strobe must match the next expected bank
    always @(negedge clk) begin
        if (bus_get_data) begin
            strobe_cnt++;
            check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("which_data", 32'(bus_which_data), 32'(exp_q.pop_front()));
                check("image_addr", 32'(bus_image_addr), 32'(exp_addr));
            end
        end
    end

    // bus responder: busy rises 2 cycles after the strobe and stays high 5 cycles
    initial begin
        int b;
        forever begin
            @(negedge clk);
            if (bus_get_data && bus_mode == 0) begin
                b = int'(bus_which_data);
                for (int i = 0; i < IMAGE_SIZE; i++)
                    bus_image_data[i*DATA_W +: DATA_W] = (b == 0) ? img_base + 16'(i) : 16'h5000 + 16'(i);
                for (int j = 0; j < LAYER_NEURONS; j++)
                    for (int i = 0; i < IMAGE_SIZE; i++)
                        bus_coeff_data[(j*IMAGE_SIZE+i)*DATA_W +: DATA_W] = {4'(b), 12'(j*64+i)};
                if (b == 2) bus_coeff_data[(3*IMAGE_SIZE+5)*DATA_W +: DATA_W] = 16'hBEEF;
                repeat (2) @(negedge clk);
                bus_busy = 1'b1;
                repeat (5) @(negedge clk);
                bus_busy = 1'b0;
            end
        end
    end

    // core responder: checks each handed-off bank, acks, then reports a result
    initial begin
        int b;
        forever begin
            @(negedge clk);
            if (core_loaded) begin
                loaded_cnt++;
                b = int'(core_bank);
                check("core_bank", 32'(b), 32'(exp_bank));
                exp_bank++;
                check("img_word7", 32'(core_image[7*DATA_W +: DATA_W]), 32'(img_base + 16'd7));
                check("w_1_2", 32'(wword(core_weights, 1, 2)), 32'({4'(b), 12'h042}));
                if (b == 2) check("w_3_5_beef", 32'(wword(core_weights, 3, 5)), 32'hBEEF);
                if (b == 3) check("w_3_5_bank3", 32'(wword(core_weights, 3, 5)), 32'h30C5);
                if (ack_delay == 0) begin
                    core_bank_ack = 1'b1;
                    @(negedge clk);
                    core_bank_ack = 1'b0;
                    if (b != NUM_BANKS-1) check("ack_same_cycle", 32'(bus_get_data), 32'd1);
                end else begin
                    @(negedge clk);
                    check("loaded_pulse", 32'(core_loaded), 32'd0);
                    repeat (ack_delay-1) @(negedge clk);
                    core_bank_ack = 1'b1;
                    @(negedge clk);
                    core_bank_ack = 1'b0;
                end
                if (b == NUM_BANKS-1) begin
                    repeat (2) @(negedge clk);
                    core_done = 1'b1;
                    @(negedge clk);
                    core_done = 1'b0;
                end
            end
        end
    end

    // driver tasks
    task automatic arm_run(input logic [ADDR_W-1:0] addr, input logic [3:0] digit, input int delay);
        for (int k = 0; k < NUM_BANKS; k++) exp_q.push_back(SEL_W'(k));
        exp_addr = addr;
        image_address = addr;
        core_digit = digit;
        ack_delay = delay;
        exp_bank = 0;
        strobe_cnt = 0;
        loaded_cnt = 0;
    endtask

    task automatic do_start();
        start_detecting = 1'b0;
        @(negedge clk);
        start_detecting = 1'b1;
        @(negedge clk);
        image_address = ~exp_addr;
        @(negedge clk);
        start_detecting = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 3000; k++) begin
            if (done_processing) break;
            @(negedge clk);
        end
        check("done_seen", 32'(done_processing), 32'd1);
    endtask

    initial begin
        int k_found;
        // reset
        #3 n_reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_seg", 32'(seven_seg), 32'h40);
        check("rst_get", 32'(bus_get_data), 32'd0);
        check("rst_loaded", 32'(core_loaded), 32'd0);
        check("rst_done", 32'(done_processing), 32'd0);
        check("rst_err", 32'(error), 32'd0);
        check("rst_addr", 32'(bus_image_addr), 32'd0);
        check("rst_img", core_image[0 +: 32], 32'd0);
        check("rst_w", core_weights[100*DATA_W +: 32], 32'd0);
        n_reset = 1'b1;
        @(negedge clk);
        check("rel_get", 32'(bus_get_data), 32'd0);

        // nominal run, digit 7
        img_base = 16'hA000;
        arm_run(10'h155, 4'd7, 3);
        do_start();
        wait_done();
        check("t1_seg", 32'(seven_seg), 32'h07);
        check("t1_err", 32'(error), 32'd0);
        check("t1_strobes", 32'(strobe_cnt), 32'd4);
        check("t1_loads", 32'(loaded_cnt), 32'd4);
        check("t1_img0", 32'(core_image[0 +: DATA_W]), 32'hA000);
        check("t1_q_empty", 32'(exp_q.size()), 32'd0);

        // start edge during WAIT_LO, then held high across DONE
        img_base = 16'hA100;
        arm_run(10'h2AA, 4'd3, 3);
        do_start();
        for (int k = 0; k < 50 && !bus_busy; k++) @(negedge clk);
        check("t4_busy", 32'(bus_busy), 32'd1);
        @(negedge clk);
        start_detecting = 1'b1;
        wait_done();
        repeat (20) @(negedge clk);
        check("t4_seg", 32'(seven_seg), 32'h4F);
        check("t4_done_hold", 32'(done_processing), 32'd1);
        check("t4_strobes", 32'(strobe_cnt), 32'd4);
        start_detecting = 1'b0;

        // timeout: the bus never answers
        bus_mode = 2;
        exp_q.push_back('0);
        exp_addr = 10'h011;
        image_address = 10'h011;
        @(negedge clk);
        start_detecting = 1'b1;
        @(negedge clk);
        check("t3_strobe", 32'(bus_get_data), 32'd1);
        k_found = 0;
        for (int k = 1; k < 3000; k++) begin
            @(negedge clk);
            if (error) begin
                k_found = k;
                break;
            end
        end
        check("t3_cycles", 32'(k_found), 32'(TIMEOUT + 1));
        check("t3_seg", 32'(seven_seg), 32'h79);
        check("t3_done", 32'(done_processing), 32'd0);
        start_detecting = 1'b0;
        bus_mode = 0;
        img_base = 16'hA200;
        arm_run(10'h033, 4'd5, 3);
        do_start();
        check("t3_err_clr", 32'(error), 32'd0);
        check("t3_seg_run", 32'(seven_seg), 32'h40);
        wait_done();
        check("t3_seg5", 32'(seven_seg), 32'h6D);

        // reset during HANDOFF of bank 2
        img_base = 16'hA300;
        arm_run(10'h0F0, 4'd1, 3);
        do_start();
        for (int k = 0; k < 500; k++) begin
            if (core_loaded && core_bank == 2'd2) break;
            @(negedge clk);
        end
        check("t5_at_bank2", 32'(core_bank), 32'd2);
        #2 n_reset = 1'b0;
        #1;
        check("t5_seg", 32'(seven_seg), 32'h40);
        check("t5_loaded", 32'(core_loaded), 32'd0);
        check("t5_bank", 32'(core_bank), 32'd0);
        check("t5_img", core_image[0 +: 32], 32'd0);
        check("t5_w", core_weights[(3*IMAGE_SIZE+5)*DATA_W +: 32], 32'd0);
        check("t5_addr", 32'(bus_image_addr), 32'd0);
        exp_q.delete();
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        check("t5_rel_get", 32'(bus_get_data), 32'd0);
        check("t5_rel_seg", 32'(seven_seg), 32'h40);
        repeat (15) @(negedge clk);

        // invalid digit with same-cycle acks
        img_base = 16'hA400;
        arm_run(10'h3C3, 4'hC, 0);
        do_start();
        wait_done();
        check("t6_seg", 32'(seven_seg), 32'h40);
        check("t6_done", 32'(done_processing), 32'd1);
        check("t6_loads", 32'(loaded_cnt), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
